// File: rtl/slave_axi_stream_if.sv
// AXI-Stream receive-side bundle: upstream beat handshake plus the
// downstream first-word-fall-through FIFO port.
interface slave_axi_stream_if #(
    parameter int N = 4
) ();
    logic             tvalid;
    logic             tready;
    logic [8*N-1:0]   tdata;
    logic [N-1:0]     tstrb;
    logic [N-1:0]     tkeep;
    logic             tlast;
    logic             tid;
    logic             tdest;
    logic             tuser;

    logic             out_valid;
    logic             out_ready;
    logic [8*N-1:0]   out_data;
    logic [N-1:0]     out_keep;
    logic             out_last;

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready,
        output out_valid, out_data, out_keep, out_last,
        input  out_ready
    );

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready,
        input  out_valid, out_data, out_keep, out_last,
        output out_ready
    );
endinterface

// File: rtl/slave_axi_stream.sv
// AXI-Stream slave: receive FIFO (first-word fall-through), per-packet beat
// and byte accounting, and a sticky protocol-violation monitor.
module slave_axi_stream #(
    parameter int n     = 4,
    parameter int DEPTH = 4
) (
    input  logic                aclk_i,
    input  logic                areset_i,
    slave_axi_stream_if.slave   s,
    output logic                pkt_done_o,
    output logic [15:0]         pkt_beats_o,
    output logic [15:0]         pkt_bytes_o,
    output logic                pkt_id_o,
    output logic                pkt_dest_o,
    output logic                protocol_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 8*n + n + 1;
    localparam int HW = 8*n + n + 2;
    localparam logic [AW:0] FULL_FILL = (AW+1)'(DEPTH);

    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    fill_q, fill_d;
    logic [15:0]    beat_cnt_q, beat_cnt_d, byte_cnt_q, byte_cnt_d;
    logic [15:0]    pkt_beats_q, pkt_beats_d, pkt_bytes_q, pkt_bytes_d;
    logic           pkt_done_q, pkt_done_d, pkt_id_q, pkt_id_d, pkt_dest_q, pkt_dest_d;
    logic           in_pkt_q, in_pkt_d, first_id_q, first_id_d, first_dest_q, first_dest_d;
    logic           err_q, err_d, stall_q, stall_d;
    logic [HW-1:0]  held_q, held_now;

    logic           tready_w, accept, null_beat, store, pop, out_valid_w;
    logic [16:0]    beat_sum, byte_sum;
    logic [15:0]    beat_inc, byte_inc;

    // tready looks only at registered fill, so a pop while full frees a slot next cycle
    assign tready_w    = (fill_q < FULL_FILL) && !areset_i;
    assign accept      = s.tvalid && tready_w;
    assign null_beat   = (s.tkeep == '0) && (s.tstrb == '0) && !s.tlast;
    assign store       = accept && !null_beat;
    assign out_valid_w = (fill_q != '0);
    assign pop         = out_valid_w && s.out_ready;

    assign s.tready    = tready_w;
    assign s.out_valid = out_valid_w;
    assign {s.out_data, s.out_keep, s.out_last} = out_valid_w ? mem_q[rd_ptr_q] : '0;

    assign beat_sum = {1'b0, beat_cnt_q} + 17'd1;
    assign byte_sum = {1'b0, byte_cnt_q} + 17'($countones(s.tkeep));
    assign beat_inc = beat_sum[16] ? 16'hFFFF : beat_sum[15:0];
    assign byte_inc = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
    assign held_now = {s.tdata, s.tkeep, s.tlast, s.tuser};

    // FIFO storage; contents need no reset because fill gates visibility
    always_ff @(posedge aclk_i) begin
        if (store) begin
            mem_q[wr_ptr_q] <= {s.tdata, s.tkeep, s.tlast};
        end
    end

    // FIFO pointers and occupancy; store and pop together keep fill unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (store) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({store, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // Packet accounting: running totals fold into the published report on tlast
    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        in_pkt_d     = in_pkt_q;
        first_id_d   = first_id_q;
        first_dest_d = first_dest_q;
        pkt_done_d   = 1'b0;
        pkt_beats_d  = pkt_beats_q;
        pkt_bytes_d  = pkt_bytes_q;
        pkt_id_d     = pkt_id_q;
        pkt_dest_d   = pkt_dest_q;
        if (store) begin
            if (!in_pkt_q) begin
                first_id_d   = s.tid;
                first_dest_d = s.tdest;
            end
            if (s.tlast) begin
                pkt_done_d  = 1'b1;
                pkt_beats_d = beat_inc;
                pkt_bytes_d = byte_inc;
                pkt_id_d    = in_pkt_q ? first_id_q   : s.tid;
                pkt_dest_d  = in_pkt_q ? first_dest_q : s.tdest;
                beat_cnt_d  = '0;
                byte_cnt_d  = '0;
                in_pkt_d    = 1'b0;
            end else begin
                beat_cnt_d  = beat_inc;
                byte_cnt_d  = byte_inc;
                in_pkt_d    = 1'b1;
            end
        end
    end

    // Protocol monitor: stalled beat must stay put, no strobe without keep, sideband fixed per packet
    always_comb begin
        err_d   = err_q;
        stall_d = s.tvalid && !tready_w;
        if (stall_q && (!s.tvalid || (held_now != held_q))) err_d = 1'b1;
        if (accept && ((s.tstrb & ~s.tkeep) != '0)) err_d = 1'b1;
        if (accept && in_pkt_q && ((s.tid != first_id_q) || (s.tdest != first_dest_q))) err_d = 1'b1;
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            beat_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            in_pkt_q     <= 1'b0;
            first_id_q   <= 1'b0;
            first_dest_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_beats_q  <= '0;
            pkt_bytes_q  <= '0;
            pkt_id_q     <= 1'b0;
            pkt_dest_q   <= 1'b0;
            err_q        <= 1'b0;
            stall_q      <= 1'b0;
            held_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            beat_cnt_q   <= beat_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            in_pkt_q     <= in_pkt_d;
            first_id_q   <= first_id_d;
            first_dest_q <= first_dest_d;
            pkt_done_q   <= pkt_done_d;
            pkt_beats_q  <= pkt_beats_d;
            pkt_bytes_q  <= pkt_bytes_d;
            pkt_id_q     <= pkt_id_d;
            pkt_dest_q   <= pkt_dest_d;
            err_q        <= err_d;
            stall_q      <= stall_d;
            held_q       <= held_now;
        end
    end

    assign pkt_done_o     = pkt_done_q;
    assign pkt_beats_o    = pkt_beats_q;
    assign pkt_bytes_o    = pkt_bytes_q;
    assign pkt_id_o       = pkt_id_q;
    assign pkt_dest_o     = pkt_dest_q;
    assign protocol_err_o = err_q;
endmodule

// File: doc/slave_axi_stream.md
SLAVE_AXI_STREAM -- requirements
Module: slave_axi_stream

Interface
REQ-001 Parameter n, default 4, tdata width in bytes (tdata = 8*n bits, tstrb/tkeep = n bits).
REQ-002 Parameter DEPTH, default 4, receive FIFO depth in beats (power of two, >= 2).
REQ-003 aclk  in  1  single clock; all state changes on its rising edge.
REQ-004 areset  in  1  reset, synchronous and active-high.
REQ-005 tvalid  in  1  upstream beat valid.
REQ-006 tready  out  1  block can accept a beat.
REQ-007 tdata  in  8*n  beat data.
REQ-008 tstrb  in  n  byte strobe.
REQ-009 tkeep  in  n  byte keep.
REQ-010 tlast  in  1  last beat of packet.
REQ-011 TID, TDEST, TUSER  in  1 each  stream sideband.
REQ-012 out_valid / out_ready  out / in  1 each  downstream beat handshake.
REQ-013 out_data, out_keep, out_last  out  8*n, n, 1  head-of-FIFO beat.
REQ-014 pkt_done  out  1  one-cycle pulse, packet closed.
REQ-015 pkt_beats, pkt_bytes  out  16 each  stored beats and kept bytes of the last closed packet.
REQ-016 pkt_id, pkt_dest  out  1 each  TID and TDEST latched at first beat of the last closed packet.
REQ-017 protocol_err  out  1  sticky protocol violation flag.

Function
REQ-018 Accept = tvalid && tready; tready SHALL equal (fill < DEPTH) && !areset, with no combinational path from tvalid.
REQ-019 Accepted beat with tkeep==0, tstrb==0, tlast==0 (null beat) SHALL be consumed and dropped: not stored, not counted.
REQ-020 Null beat with tlast==1 SHALL be stored as a zero-keep beat so the packet boundary reaches the output.
REQ-021 All other accepted beats SHALL be stored as {tdata, tkeep, tlast}; tstrb is not stored.
REQ-022 FIFO is first-word fall-through: a beat accepted at edge k drives out_* with out_valid=1 in the cycle after edge k when the FIFO was empty.
REQ-023 out_valid = (fill != 0); pop on out_valid && out_ready; out_* SHALL hold stable while out_valid && !out_ready.
REQ-024 Simultaneous store and pop SHALL leave fill unchanged; pointers wrap modulo DEPTH.
REQ-025 Full (fill==DEPTH): tready=0; a pop in that cycle SHALL raise tready in the following cycle, not the same cycle.
REQ-026 Running counters: beat_cnt +1 per stored beat, byte_cnt + popcount(tkeep); both SHALL saturate at 0xFFFF.
REQ-027 On accepted tlast: in the next cycle pkt_done=1 for exactly one cycle, with pkt_beats/pkt_bytes holding totals including that beat; running counters clear to 0 in the same edge.
REQ-028 pkt_id/pkt_dest SHALL be latched from TID/TDEST on the first accepted beat of each packet and published with pkt_done; they hold until the next pkt_done.
REQ-029 protocol_err SHALL set on: (a) tvalid high and tready low in cycle c, then tvalid low in c+1; (b) same stall, then tdata, tkeep or tlast changed in c+1; (c) any byte with tkeep=0, tstrb=1 in an accepted beat; (d) TID or TDEST differing from the first beat of the same packet.
REQ-030 protocol_err SHALL clear only on reset; offending beats are still accepted normally.
REQ-031 TUSER SHALL be ignored except when sampled for REQ-029(b) stability checks.

Reset
REQ-032 While areset=1 at an edge: FIFO emptied, counters cleared, all outputs 0 (tready, out_valid, pkt_done, pkt_beats, pkt_bytes, pkt_id, pkt_dest, protocol_err), stall tracking cleared.
REQ-033 Reset asserted mid-packet SHALL discard the partial packet without pulsing pkt_done; tready SHALL return to 1 in the first cycle after areset deasserts.

Verification
REQ-034 Reset, then 3-beat packet (tkeep=F,F,3; tlast on beat 3), out_ready=1 -> three beats out in order; pkt_done pulses once with pkt_beats=3, pkt_bytes=10.
REQ-035 out_ready=0, send 5 beats (DEPTH=4) -> tready drops after 4th accept; 5th held; raise out_ready -> 5th accepted one cycle after first pop, order preserved.
REQ-036 Null beat (keep=0, strb=0, last=0) between two data beats -> dropped, pkt_beats=2; null beat with tlast=1 -> stored, out_last=1, out_keep=0.
REQ-037 During a full stall, drop tvalid or change tdata -> protocol_err=1 and stays 1 until areset.
REQ-038 Beat with tkeep=0, tstrb=F -> protocol_err=1; TID changes from 1 to 0 mid-packet -> protocol_err=1; pkt_id reports 1.
REQ-039 Assert areset after 2 beats of a packet -> all outputs 0, no pkt_done; next full packet reports only its own counts.
